cfg_reg_arbiter: RTL and testbench
==================================

# cfg_reg_arbiter

- Owns the PWM/output-enable configuration register bank.
- Shares its single write path between two requesters:
  - port 0: the SPI frame decoder;
  - port 1: the on-chip control/test sequencer.
- After reset, a boot sequence loads parameterised default values before either port is served.
- Valid/ready handshake per port, round-robin arbitration, one committed write per cycle; outputs drive the PWM and output-enable logic directly.

## Interface
- DEF_OUT_7_0, 8'h00, boot value for register 0x00
- DEF_OUT_15_8, 8'h00, boot value for register 0x01
- DEF_PWM_7_0, 8'h00, boot value for register 0x02
- DEF_PWM_15_8, 8'h00, boot value for register 0x03
- DEF_DUTY, 8'h80, boot value for register 0x04
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req0_valid  input  1  port 0 write request
- req0_addr  input  7  port 0 register address
- req0_data  input  8  port 0 write data
- req0_ready  output  1  port 0 accepted this cycle (combinational)
- req1_valid / req1_addr / req1_data / req1_ready  same as port 0, for port 1
- en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  output  8 each  register bank
- boot_done  output  1  high once the boot sequence completes
- wr_commit  output  1  one-cycle pulse: a register was written
- wr_src  output  1  port of the last commit (0/1)
- wr_err  output  1  one-cycle pulse: accepted request was rejected (bad address or locked)

## Operation
- FSM states:
  - BOOT: a 3-bit boot index counts 0..4; each cycle it writes DEF_* into register[index]. After index 4 → RUN.
  - RUN: arbitration active. Never leaves RUN except by reset.
- In BOOT: req0_ready = req1_ready = 0, wr_commit = 0, wr_err = 0. boot_done rises on the BOOT→RUN edge.
- Handshake: a transfer occurs on a clk edge where valid && ready. Requesters hold addr/data stable while valid && !ready.
- Arbitration in RUN, all cases:
  - Only one port valid: that port's ready = 1.
  - Both valid: grant the port that was not last granted. The last-granted pointer updates only on a transfer and resets to 1, so port 0 wins the first tie.
  - Never both ready in the same cycle.
  - Ready does not depend on the address.
- Address decode on transfer:
  - 0x00–0x04 write the corresponding register.
  - 0x05 is the lock register when REG_ARB_LOCK_EN is defined; otherwise invalid.
  - Any other address is invalid: accepted (ready given), no register change, wr_err pulse.
- wr_commit / wr_src: registered on the transfer edge for valid writes. wr_src holds its value between commits.

## Timing
- Reset values:
  - all five registers 8'h00;
  - boot_done 0, wr_commit 0, wr_err 0, wr_src 0;
  - FSM in BOOT, boot index 0, pointer 1, lock 0.
- Boot timing: five cycles after rst_n deassertion. Registers 0x00..0x04 take their DEF_* values on successive edges; boot_done = 1 from the 6th edge.
- Write latency: the register updates on the transfer edge and is visible on the outputs from then on (zero added cycles). wr_commit / wr_err are high for exactly the one cycle after that edge.
- Throughput: one transfer per cycle sustained. With both ports continuously valid, grants alternate 0,1,0,1 (after the first tie).
- Reset mid-operation: asynchronously clears everything to the reset values and restarts BOOT. A pending request is dropped; the requester must re-present it.
- Boot overrides requests: a request asserted during BOOT waits, holding valid, and is served in the first RUN cycle.

## Configuration
- REG_ARB_LOCK_EN defined:
  - Address 0x05 holds a lock bit (data[0]), writable by port 0 only.
  - While lock = 1, port 1 writes to 0x00–0x05 are accepted, do not change any register, and pulse wr_err.
  - Port 1 write to 0x05 is always rejected.
  - Lock resets to 0 and is not touched by BOOT.
- Undefined: no lock storage; 0x05 is an invalid address for both ports (wr_err); port 1 has the same rights as port 0.

## Test plan
- Boot: DEF_DUTY=8'h80, others 0; release reset, no requests → pwm_duty_cycle = 8'h80 after 5 edges; boot_done = 1 on 6th; readies 0 throughout BOOT.
- Single write: port 0 addr 0x02, data 8'hA5 → req0_ready = 1 same cycle; en_reg_pwm_7_0 = 8'hA5 after the edge; wr_commit = 1, wr_src = 0 for one cycle.
- Tie and round-robin: both valid for 4 cycles (port 0 → 0x00/8'h11, port 1 → 0x01/8'h22) → grant order 0,1,0,1; never both ready in one cycle.
- Invalid address: port 1 addr 0x7F, data 8'hFF → accepted, wr_err pulse, all registers unchanged (0x05 also invalid when lock disabled).
- Lock (REG_ARB_LOCK_EN): port 0 writes 0x05/8'h01, then port 1 writes 0x04/8'h10 → wr_err, duty unchanged; port 0 writes 0x05/8'h00, port 1 repeats → duty = 8'h10.
- Mid-operation reset: rst_n low during alternating writes → outputs 0 immediately; BOOT reruns; held request served in first RUN cycle.

Source files
------------

// File: rtl/cfg_reg_arbiter.sv
// PWM/output-enable configuration register bank: boot loader plus a two-port round-robin write path.
// Define REG_ARB_LOCK_EN to add the port-1 write lock at address 0x05.
module cfg_reg_arbiter #(
  parameter logic [7:0] DEF_OUT_7_0  = 8'h00,
  parameter logic [7:0] DEF_OUT_15_8 = 8'h00,
  parameter logic [7:0] DEF_PWM_7_0  = 8'h00,
  parameter logic [7:0] DEF_PWM_15_8 = 8'h00,
  parameter logic [7:0] DEF_DUTY     = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       boot_done,
  output logic       wr_commit,
  output logic       wr_src,
  output logic       wr_err
);

  localparam int unsigned AW   = 7;
  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 5;
  localparam int unsigned IW   = 3;

  localparam logic [DW-1:0] DEFS [NREG] = '{DEF_OUT_7_0, DEF_OUT_15_8, DEF_PWM_7_0,
                                            DEF_PWM_15_8, DEF_DUTY};

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state;
  logic [IW-1:0] boot_idx;
  logic          last_gnt;
  logic [DW-1:0] regs [NREG];

  logic          xfer;
  logic          sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          reg_hit;
  logic          wr_ok;

  // Round-robin grant; the pointer favours the port that was not served last.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == RUN) begin
      req0_ready = req0_valid && (!req1_valid || last_gnt);
      req1_ready = req1_valid && (!req0_valid || !last_gnt);
    end
  end

  assign xfer    = req0_ready || req1_ready;
  assign sel     = req1_ready;
  assign addr    = sel ? req1_addr : req0_addr;
  assign data    = sel ? req1_data : req0_data;
  assign reg_hit = addr < AW'(NREG);

`ifdef REG_ARB_LOCK_EN
  localparam int unsigned LOCK_ADDR = 5;

  logic lock;
  logic lock_hit;

  assign lock_hit = addr == AW'(LOCK_ADDR);
  // Port 1 may never touch the lock, and is shut out of the bank while it is set.
  assign wr_ok    = sel ? (reg_hit && !lock) : (reg_hit || lock_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock <= 1'b0;
    end else if (xfer && !sel && lock_hit) begin
      lock <= data[0];
    end
  end
`else
  assign wr_ok = reg_hit;
`endif

  // Boot loader and write commit; status pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      boot_idx  <= '0;
      last_gnt  <= 1'b1;
      boot_done <= 1'b0;
      wr_commit <= 1'b0;
      wr_err    <= 1'b0;
      wr_src    <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      wr_commit <= 1'b0;
      wr_err    <= 1'b0;
      case (state)
        BOOT: begin
          if (boot_idx == IW'(NREG)) begin
            state     <= RUN;
            boot_done <= 1'b1;
          end else begin
            regs[boot_idx] <= DEFS[boot_idx];
            boot_idx       <= boot_idx + IW'(1);
          end
        end
        RUN: begin
          if (xfer) begin
            last_gnt <= sel;
            if (wr_ok) begin
              if (reg_hit) begin
                regs[IW'(addr)] <= data;
              end
              wr_commit <= 1'b1;
              wr_src    <= sel;
            end else begin
              wr_err <= 1'b1;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign en_reg_out_7_0  = regs[0];
  assign en_reg_out_15_8 = regs[1];
  assign en_reg_pwm_7_0  = regs[2];
  assign en_reg_pwm_15_8 = regs[3];
  assign pwm_duty_cycle  = regs[4];

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Self-checking bench for cfg_reg_arbiter against a rule-level model of the register bank.
module tb_cfg_reg_arbiter;

  localparam logic [7:0] D0 = 8'h3C;
  localparam logic [7:0] D1 = 8'hC3;
  localparam logic [7:0] D2 = 8'h5A;
  localparam logic [7:0] D3 = 8'h0F;
  localparam logic [7:0] D4 = 8'h80;
`ifdef REG_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [6:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       boot_done, wr_commit, wr_src, wr_err;

  int n_vec = 0;
  int n_err = 0;

  cfg_reg_arbiter #(
    .DEF_OUT_7_0 (D0),
    .DEF_OUT_15_8(D1),
    .DEF_PWM_7_0 (D2),
    .DEF_PWM_15_8(D3),
    .DEF_DUTY    (D4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .boot_done      (boot_done),
    .wr_commit      (wr_commit),
    .wr_src         (wr_src),
    .wr_err         (wr_err)
  );

  always #5 clk = ~clk;

  wire [39:0] dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                          en_reg_out_15_8, en_reg_out_7_0};
  wire [3:0]  dut_flags = {boot_done, wr_commit, wr_err, wr_src};

  // Reference model: register array, lock bit, last grant and boot progress.
  logic [7:0] m_regs [5];
  logic [7:0] m_def  [5];
  bit m_lock, m_run, m_done, m_commit, m_err, m_src;
  int m_last, m_boot;

  function automatic logic [39:0] model_regs();
    return {m_regs[4], m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
  endfunction

  function automatic logic [3:0] model_flags();
    return {m_done, m_commit, m_err, m_src};
  endfunction

  function automatic int grant(logic v0, logic v1);
    if (!m_run) return -1;
    if (v0 && v1) return (m_last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] exp_rdy(int g);
    if (g == 0) return 2'b01;
    if (g == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
    m_lock = 0; m_run = 0; m_done = 0; m_commit = 0; m_err = 0; m_src = 0;
    m_last = 1; m_boot = 0;
  endtask

  task automatic model_edge();
    int g;
    logic [6:0] a;
    logic [7:0] d;
    bit ok;
    m_commit = 0;
    m_err    = 0;
    if (!m_run) begin
      if (m_boot < 5) m_regs[m_boot] = m_def[m_boot];
      else begin m_run = 1; m_done = 1; end
      m_boot++;
      return;
    end
    g = grant(req0_valid, req1_valid);
    if (g < 0) return;
    m_last = g;
    a = (g == 1) ? req1_addr : req0_addr;
    d = (g == 1) ? req1_data : req0_data;
    if (a < 7'd5) ok = !(LOCK && g == 1 && m_lock);
    else if (LOCK && a == 7'd5) begin
      ok = (g == 0);
      if (ok) m_lock = d[0];
    end else ok = 0;
    if (ok) begin
      if (a < 7'd5) m_regs[a] = d;
      m_commit = 1;
      m_src    = (g == 1);
    end else m_err = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req0_addr = '0; req0_data = '0;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #3;
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    req0_valid = 1;
    req1_valid = 1;
    rst_n = 1;
    #1 rst_n = 0;
    model_reset();
    #2;
    n_vec++;
    if (dut_regs !== 40'h0) begin n_err++; $display("FAIL reset_regs: got %h expected %h", dut_regs, 40'h0); end
    n_vec++;
    if (dut_flags !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b expected %b", dut_flags, 4'b0); end
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); end
    idle();
  endtask

  task automatic test_boot();
    @(posedge clk);
    #1 rst_n = 1;
    for (int k = 1; k <= 6; k++) begin
      n_vec++;
      if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL boot_ready edge %0d: got %b expected 00", k, {req1_ready, req0_ready}); end
      tick();
      n_vec++;
      if (dut_regs !== model_regs()) begin n_err++; $display("FAIL boot_regs edge %0d: got %h expected %h", k, dut_regs, model_regs()); end
      n_vec++;
      if (dut_flags !== model_flags()) begin n_err++; $display("FAIL boot_flags edge %0d: got %b expected %b", k, dut_flags, model_flags()); end
    end
    n_vec++;
    if (pwm_duty_cycle !== D4 || boot_done !== 1'b1) begin n_err++; $display("FAIL boot_end: duty %h done %b expected %h 1", pwm_duty_cycle, boot_done, D4); end
  endtask

  task automatic test_single_write();
    req0_valid = 1; req0_addr = 7'h02; req0_data = 8'hA5;
    #1;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b expected 01", {req1_ready, req0_ready}); end
    tick();
    idle();
    n_vec++;
    if (en_reg_pwm_7_0 !== 8'hA5) begin n_err++; $display("FAIL single_reg: got %h expected a5", en_reg_pwm_7_0); end
    n_vec++;
    if ({wr_commit, wr_err, wr_src} !== 3'b100) begin n_err++; $display("FAIL single_pulse: got %b expected 100", {wr_commit, wr_err, wr_src}); end
    tick();
    n_vec++;
    if (wr_commit !== 1'b0) begin n_err++; $display("FAIL single_pulse_width: got %b expected 0", wr_commit); end
  endtask

  task automatic test_invalid();
    req1_valid = 1; req1_addr = 7'h7F; req1_data = 8'hFF;
    #1;
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b10) begin n_err++; $display("FAIL invalid_ready: got %b expected 10", {req1_ready, req0_ready}); end
    tick();
    n_vec++;
    if ({wr_commit, wr_err} !== 2'b01) begin n_err++; $display("FAIL invalid_err: got %b expected 01", {wr_commit, wr_err}); end
    n_vec++;
    if (dut_regs !== model_regs()) begin n_err++; $display("FAIL invalid_regs: got %h expected %h", dut_regs, model_regs()); end
    req1_addr = 7'h05; req1_data = 8'h01;
    tick();
    n_vec++;
    if ({wr_commit, wr_err, wr_src} !== 3'b010) begin n_err++; $display("FAIL invalid_p1_05: got %b expected 010", {wr_commit, wr_err, wr_src}); end
    idle();
    req0_valid = 1; req0_addr = 7'h05; req0_data = 8'h00;
    tick();
    idle();
    n_vec++;
    if (dut_flags !== model_flags()) begin n_err++; $display("FAIL p0_05: got %b expected %b", dut_flags, model_flags()); end
    n_vec++;
    if (dut_regs !== model_regs()) begin n_err++; $display("FAIL p0_05_regs: got %h expected %h", dut_regs, model_regs()); end
  endtask

`ifdef REG_ARB_LOCK_EN
  task automatic test_lock();
    logic [7:0] duty_before;
    duty_before = m_regs[4];
    req0_valid = 1; req0_addr = 7'h05; req0_data = 8'h01;
    tick();
    idle();
    n_vec++;
    if ({wr_commit, wr_err} !== 2'b10) begin n_err++; $display("FAIL lock_set: got %b expected 10", {wr_commit, wr_err}); end
    req1_valid = 1; req1_addr = 7'h04; req1_data = 8'h10;
    tick();
    idle();
    n_vec++;
    if ({wr_commit, wr_err} !== 2'b01 || pwm_duty_cycle !== duty_before) begin
      n_err++; $display("FAIL lock_block: flags %b duty %h expected 01 %h", {wr_commit, wr_err}, pwm_duty_cycle, duty_before);
    end
    req0_valid = 1; req0_addr = 7'h05; req0_data = 8'h00;
    tick();
    idle();
    req1_valid = 1; req1_addr = 7'h04; req1_data = 8'h10;
    tick();
    idle();
    n_vec++;
    if ({wr_commit, wr_err, wr_src} !== 3'b101 || pwm_duty_cycle !== 8'h10) begin
      n_err++; $display("FAIL lock_clear: flags %b duty %h expected 101 10", {wr_commit, wr_err, wr_src}, pwm_duty_cycle);
    end
  endtask
`endif

  task automatic test_round_robin();
    int order [4] = '{0, 1, 0, 1};
    do_reset();
    repeat (6) tick();
    req0_valid = 1; req0_addr = 7'h00; req0_data = 8'h11;
    req1_valid = 1; req1_addr = 7'h01; req1_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if ({req1_ready, req0_ready} !== exp_rdy(order[i])) begin
        n_err++; $display("FAIL rr_grant %0d: got %b expected %b", i, {req1_ready, req0_ready}, exp_rdy(order[i]));
      end
      tick();
    end
    idle();
    n_vec++;
    if ({en_reg_out_15_8, en_reg_out_7_0, wr_src} !== {8'h22, 8'h11, 1'b1}) begin
      n_err++; $display("FAIL rr_result: got %h %h %b expected 22 11 1", en_reg_out_15_8, en_reg_out_7_0, wr_src);
    end
  endtask

  function automatic logic [6:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 7'($urandom);
    return 7'($urandom_range(0, 6));
  endfunction

  task automatic test_random();
    bit p0, p1;
    logic [6:0] a0, a1;
    logic [7:0] d0, d1;
    int g;
    p0 = 0; p1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < 600; i++) begin
      if (!p0 && $urandom_range(0, 9) < 6) begin p0 = 1; a0 = rand_addr(); d0 = 8'($urandom); end
      if (!p1 && $urandom_range(0, 9) < 6) begin p1 = 1; a1 = rand_addr(); d1 = 8'($urandom); end
      req0_valid = p0; req0_addr = a0; req0_data = d0;
      req1_valid = p1; req1_addr = a1; req1_data = d1;
      g = grant(p0, p1);
      #1;
      n_vec++;
      if ({req1_ready, req0_ready} !== exp_rdy(g)) begin
        n_err++; $display("FAIL rand_ready %0d: got %b expected %b", i, {req1_ready, req0_ready}, exp_rdy(g));
      end
      tick();
      n_vec++;
      if (dut_regs !== model_regs()) begin n_err++; $display("FAIL rand_regs %0d: got %h expected %h", i, dut_regs, model_regs()); end
      n_vec++;
      if (dut_flags !== model_flags()) begin n_err++; $display("FAIL rand_flags %0d: got %b expected %b", i, dut_flags, model_flags()); end
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end
    idle();
  endtask

  task automatic test_mid_reset();
    int cnt;
    req0_valid = 1; req0_addr = 7'h00; req0_data = 8'h5E;
    req1_valid = 1; req1_addr = 7'h01; req1_data = 8'hE5;
    repeat (3) tick();
    rst_n = 0;
    #1;
    model_reset();
    n_vec++;
    if (dut_regs !== 40'h0 || dut_flags !== 4'b0) begin
      n_err++; $display("FAIL midrst_clear: regs %h flags %b expected 0 0", dut_regs, dut_flags);
    end
    n_vec++;
    if ({req1_ready, req0_ready} !== 2'b00) begin n_err++; $display("FAIL midrst_ready: got %b expected 00", {req1_ready, req0_ready}); end
    idle();
    req0_valid = 1; req0_addr = 7'h03; req0_data = 8'h77;
    #2 rst_n = 1;
    cnt = 0;
    while (!req0_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt !== 6) begin n_err++; $display("FAIL midrst_first_grant: got %0d edges expected 6", cnt); end
    tick();
    idle();
    n_vec++;
    if (en_reg_pwm_15_8 !== 8'h77 || wr_commit !== 1'b1) begin
      n_err++; $display("FAIL midrst_served: reg %h commit %b expected 77 1", en_reg_pwm_15_8, wr_commit);
    end
    n_vec++;
    if (dut_regs !== model_regs()) begin n_err++; $display("FAIL midrst_regs: got %h expected %h", dut_regs, model_regs()); end
  endtask

  initial begin
    m_def[0] = D0; m_def[1] = D1; m_def[2] = D2; m_def[3] = D3; m_def[4] = D4;
    test_reset();
    test_boot();
    test_single_write();
    test_invalid();
`ifdef REG_ARB_LOCK_EN
    test_lock();
`endif
    test_round_robin();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
